// File: rtl/pixel_proc_pkg.sv
// Shared types and helpers for the camera-side pixel processor.
package pixel_proc_pkg;

  typedef enum logic [2:0] {
    MODE_PASS  = 3'd0,
    MODE_BIN   = 3'd1,
    MODE_RED   = 3'd2,
    MODE_GREEN = 3'd3,
    MODE_BLUE  = 3'd4,
    MODE_GRAD  = 3'd5
  } mode_t;

  localparam logic [3:0] COLOR_MID = 4'd8;

  function automatic logic [3:0] get_r(input logic [15:0] p);
    return p[15:12];
  endfunction

  function automatic logic [3:0] get_g(input logic [15:0] p);
    return p[10:7];
  endfunction

  function automatic logic [3:0] get_b(input logic [15:0] p);
    return p[4:1];
  endfunction

  // Reserved encodings 6-7 fall back to passthrough.
  function automatic mode_t decode_mode(input logic [2:0] m);
    return (m > 3'd5) ? MODE_PASS : mode_t'(m);
  endfunction

endpackage

// File: rtl/pixel_proc_writer_if.sv
// Frame-buffer write bus: strobe, raster address and {R,G,B} data.
interface pixel_proc_writer_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned CH_W   = 4
);
  logic              wr_en_out;
  logic [ADDR_W-1:0] wr_addr_out;
  logic [3*CH_W-1:0] wr_data_out;

  modport master (output wr_en_out, output wr_addr_out, output wr_data_out);
  modport slave  (input wr_en_out, input wr_addr_out, input wr_data_out);
endinterface

// File: rtl/pixel_mode_alu.sv
// Combinational per-pixel mode evaluation: output colour and the dark decision.
module pixel_mode_alu
  import pixel_proc_pkg::*;
#(
  parameter int unsigned CH_W = 4
) (
  input  logic [15:0]       cur,
  input  logic [15:0]       prev,
  input  mode_t             mode,
  input  logic [4:0]        thresh,
  output logic [3*CH_W-1:0] data,
  output logic              dark
);

  function automatic logic [CH_W-1:0] align(input logic [3:0] c);
    logic [CH_W-1:0] v;
    v = '0;
    v[CH_W-1 -: 4] = c;
    return v;
  endfunction

  function automatic logic [3:0] absdiff(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  logic [3:0]      r, g, b, pr, pg, pb;
  logic [4:0]      luma;
  logic [CH_W-1:0] full, zero;
  logic            unused_lsbs;

  assign r    = get_r(cur);
  assign g    = get_g(cur);
  assign b    = get_b(cur);
  assign pr   = get_r(prev);
  assign pg   = get_g(prev);
  assign pb   = get_b(prev);
  assign full = '1;
  assign zero = '0;
  assign unused_lsbs = ^{cur[11], cur[6:5], cur[0], prev[11], prev[6:5], prev[0]};

  assign luma = 5'(r >> 2) + 5'(g >> 1) + 5'(b >> 2);
  assign dark = (luma <= thresh);

  always_comb begin
    data = '0;
    case (mode)
      MODE_BIN:   data = dark ? '0 : '1;
      MODE_RED:   if (r > COLOR_MID && g < COLOR_MID && b < COLOR_MID) data = {full, zero, zero};
      MODE_GREEN: if (g > COLOR_MID && r < COLOR_MID && b < COLOR_MID) data = {zero, full, zero};
      MODE_BLUE:  if (b > COLOR_MID && r < COLOR_MID && g < COLOR_MID) data = {zero, zero, full};
      MODE_GRAD:  data = {align(absdiff(r, pr)), align(absdiff(g, pg)), align(absdiff(b, pb))};
      default:    data = {align(r), align(g), align(b)};
    endcase
  end

endmodule

// File: rtl/pixel_proc_writer.sv
// Pixel processor and frame-buffer writer, 2-stage pipeline in the pclk_in domain.
// Define PIXEL_PROC_BIN_EN to enable the bin_* dark-pixel stream.
module pixel_proc_writer
  import pixel_proc_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 320,
  parameter int unsigned V_ACTIVE = 240,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned CH_W     = 4,
  localparam int unsigned X_W     = $clog2(H_ACTIVE),
  localparam int unsigned Y_W     = $clog2(V_ACTIVE)
) (
  input  logic                      pclk_in,
  input  logic                      reset,
  input  logic [15:0]               pixel_in,
  input  logic                      pixel_valid_in,
  input  logic                      frame_done_in,
  input  logic [2:0]                mode_in,
  input  logic [4:0]                thresh_in,
  pixel_proc_writer_if.master       wr,
  output logic                      bin_valid_out,
  output logic                      bin_bit_out,
  output logic [X_W-1:0]            bin_x_out,
  output logic [Y_W-1:0]            bin_y_out,
  output logic                      frame_start_out,
  output logic                      overflow_out,
  output logic                      short_frame_out
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] Total = CNT_W'(H_ACTIVE * V_ACTIVE);

  typedef enum logic {StWaitSof, StCapture} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [X_W-1:0]    col_q;
  logic [Y_W-1:0]    row_q;
  logic [15:0]       last_pix_q;
  mode_t             mode_q;
  logic [4:0]        thresh_q;
  logic              overflow_q, short_q;
  logic              s1_valid_q, s1_first_q;
  logic [15:0]       s1_cur_q, s1_prev_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [X_W-1:0]    s1_x_q;
  logic [Y_W-1:0]    s1_y_q;

  logic capturing, accept, drop, first_px;

  assign capturing = (state_q == StCapture) && pixel_valid_in;
  assign accept    = capturing && (cnt_q < Total);
  assign drop      = capturing && !accept;
  assign first_px  = capturing && (cnt_q == '0);

  // Frame FSM, raster counters and pipeline stage 1.
  always_ff @(posedge pclk_in) begin
    if (reset) begin
      state_q    <= StWaitSof;
      cnt_q      <= '0;
      col_q      <= '0;
      row_q      <= '0;
      last_pix_q <= '0;
      mode_q     <= MODE_PASS;
      thresh_q   <= '0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_cur_q   <= '0;
      s1_prev_q  <= '0;
      s1_addr_q  <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_cur_q   <= pixel_in;
        s1_prev_q  <= (col_q == '0) ? pixel_in : last_pix_q;
        s1_addr_q  <= cnt_q[ADDR_W-1:0];
        s1_x_q     <= col_q;
        s1_y_q     <= row_q;
        s1_first_q <= (cnt_q == '0);
        last_pix_q <= pixel_in;
        cnt_q      <= cnt_q + 1'b1;
        if (col_q == X_W'(H_ACTIVE - 1)) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (first_px) begin
        mode_q     <= decode_mode(mode_in);
        thresh_q   <= thresh_in;
        overflow_q <= 1'b0;
        short_q    <= 1'b0;
      end
      if (drop) overflow_q <= 1'b1;
      // A pixel coinciding with frame_done still counts toward the ending frame.
      if (frame_done_in) begin
        state_q <= StCapture;
        cnt_q   <= '0;
        col_q   <= '0;
        row_q   <= '0;
        if (state_q == StCapture && (cnt_q + CNT_W'(accept)) < Total) short_q <= 1'b1;
      end
    end
  end

  logic [3*CH_W-1:0] alu_data;
  logic              alu_dark;

  pixel_mode_alu #(
    .CH_W (CH_W)
  ) u_alu (
    .cur    (s1_cur_q),
    .prev   (s1_prev_q),
    .mode   (mode_q),
    .thresh (thresh_q),
    .data   (alu_data),
    .dark   (alu_dark)
  );

  logic              wr_en_q, frame_start_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [3*CH_W-1:0] wr_data_q;

  always_ff @(posedge pclk_in) begin
    if (reset) begin
      wr_en_q       <= 1'b0;
      frame_start_q <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
    end else begin
      wr_en_q       <= s1_valid_q;
      frame_start_q <= s1_valid_q && s1_first_q;
      if (s1_valid_q) begin
        wr_addr_q <= s1_addr_q;
        wr_data_q <= alu_data;
      end
    end
  end

  assign wr.wr_en_out    = wr_en_q;
  assign wr.wr_addr_out  = wr_addr_q;
  assign wr.wr_data_out  = wr_data_q;
  assign frame_start_out = frame_start_q;
  assign overflow_out    = overflow_q;
  assign short_frame_out = short_q;

`ifdef PIXEL_PROC_BIN_EN
  logic           bin_valid_q, bin_bit_q;
  logic [X_W-1:0] bin_x_q;
  logic [Y_W-1:0] bin_y_q;

  always_ff @(posedge pclk_in) begin
    if (reset) begin
      bin_valid_q <= 1'b0;
      bin_bit_q   <= 1'b0;
      bin_x_q     <= '0;
      bin_y_q     <= '0;
    end else begin
      bin_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        bin_bit_q <= alu_dark;
        bin_x_q   <= s1_x_q;
        bin_y_q   <= s1_y_q;
      end
    end
  end

  assign bin_valid_out = bin_valid_q;
  assign bin_bit_out   = bin_bit_q;
  assign bin_x_out     = bin_x_q;
  assign bin_y_out     = bin_y_q;
`else
  logic unused_bin;
  assign unused_bin    = ^{alu_dark, s1_x_q, s1_y_q};
  assign bin_valid_out = 1'b0;
  assign bin_bit_out   = 1'b0;
  assign bin_x_out     = '0;
  assign bin_y_out     = '0;
`endif

endmodule

// File: tb/tb_pixel_proc_writer.sv
// Scoreboard bench for pixel_proc_writer on a reduced 10x6 frame.
module tb_pixel_proc_writer;

  localparam int unsigned H     = 10;
  localparam int unsigned V     = 6;
  localparam int unsigned AW    = 6;
  localparam int unsigned CW    = 4;
  localparam int unsigned TOTAL = H * V;

  logic        pclk_in = 1'b0;
  logic        reset;
  logic [15:0] pixel_in;
  logic        pixel_valid_in, frame_done_in;
  logic [2:0]  mode_in;
  logic [4:0]  thresh_in;
  logic        bin_valid_out, bin_bit_out, frame_start_out, overflow_out, short_frame_out;
  logic [3:0]  bin_x_out;
  logic [2:0]  bin_y_out;

  always #5 pclk_in = ~pclk_in;

  pixel_proc_writer_if #(.ADDR_W(AW), .CH_W(CW)) wr_if ();

  pixel_proc_writer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .ADDR_W   (AW),
    .CH_W     (CW)
  ) dut (
    .pclk_in         (pclk_in),
    .reset           (reset),
    .pixel_in        (pixel_in),
    .pixel_valid_in  (pixel_valid_in),
    .frame_done_in   (frame_done_in),
    .mode_in         (mode_in),
    .thresh_in       (thresh_in),
    .wr              (wr_if),
    .bin_valid_out   (bin_valid_out),
    .bin_bit_out     (bin_bit_out),
    .bin_x_out       (bin_x_out),
    .bin_y_out       (bin_y_out),
    .frame_start_out (frame_start_out),
    .overflow_out    (overflow_out),
    .short_frame_out (short_frame_out)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [11:0]   data;
    logic          dark;
    logic [3:0]    x;
    logic [2:0]    y;
    logic          first;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   in_cap = 1'b0;
  int   cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write beat must match the oldest expected entry.
  always @(negedge pclk_in) begin
    exp_t e;
    if (wr_if.wr_en_out === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 wr_if.wr_addr_out, wr_if.wr_data_out);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 32'(wr_if.wr_addr_out), 32'(e.addr));
        chk("wr_data", 32'(wr_if.wr_data_out), 32'(e.data));
        chk("frame_start", 32'(frame_start_out), 32'(e.first));
`ifdef PIXEL_PROC_BIN_EN
        chk("bin_valid", 32'(bin_valid_out), 32'd1);
        chk("bin_bit", 32'(bin_bit_out), 32'(e.dark));
        chk("bin_x", 32'(bin_x_out), 32'(e.x));
        chk("bin_y", 32'(bin_y_out), 32'(e.y));
`else
        chk("bin_valid_tied", 32'(bin_valid_out), 32'd0);
`endif
      end
    end
  end

  task automatic px(input logic [15:0] p, input logic [11:0] d, input bit dk, input bit fd = 1'b0);
    exp_t e;
    pixel_in       = p;
    pixel_valid_in = 1'b1;
    frame_done_in  = fd;
    if (in_cap && cnt < int'(TOTAL)) begin
      e.addr  = AW'(cnt);
      e.data  = d;
      e.dark  = dk;
      e.x     = 4'(cnt % H);
      e.y     = 3'(cnt / H);
      e.first = (cnt == 0);
      q.push_back(e);
      cnt++;
    end
    if (fd) begin
      in_cap = 1'b1;
      cnt    = 0;
    end
    @(posedge pclk_in);
    #1;
    pixel_valid_in = 1'b0;
    frame_done_in  = 1'b0;
  endtask

  task automatic fdone();
    frame_done_in = 1'b1;
    in_cap        = 1'b1;
    cnt           = 0;
    @(posedge pclk_in);
    #1;
    frame_done_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk_in);
    #1;
  endtask

  logic [15:0] gp [12] = '{16'h0000, 16'h0000, 16'h8410, 16'h8410, 16'h0000, 16'h0000,
                           16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8410, 16'h0000};
  logic [11:0] ge [12] = '{12'h000, 12'h000, 12'h888, 12'h000, 12'h888, 12'h000,
                           12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h888};
  bit          gd [12] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 0, 1};

  initial begin
    reset          = 1'b1;
    pixel_in       = '0;
    pixel_valid_in = 1'b0;
    frame_done_in  = 1'b0;
    mode_in        = 3'd0;
    thresh_in      = 5'd5;
    repeat (3) @(posedge pclk_in);
    #1;
    reset = 1'b0;
    chk("rst_wr_en", 32'(wr_if.wr_en_out), 32'd0);
    chk("rst_wr_addr", 32'(wr_if.wr_addr_out), 32'd0);
    chk("rst_wr_data", 32'(wr_if.wr_data_out), 32'd0);
    chk("rst_bin_valid", 32'(bin_valid_out), 32'd0);
    chk("rst_bin_bit", 32'(bin_bit_out), 32'd0);
    chk("rst_bin_x", 32'(bin_x_out), 32'd0);
    chk("rst_bin_y", 32'(bin_y_out), 32'd0);
    chk("rst_frame_start", 32'(frame_start_out), 32'd0);
    chk("rst_overflow", 32'(overflow_out), 32'd0);
    chk("rst_short", 32'(short_frame_out), 32'd0);

    // Pixels before the first frame_done are discarded.
    for (int i = 0; i < 5; i++) px(16'hFFFF, 12'hFFF, 1'b0);
    idle(3);
    fdone();

    // Exact-size passthrough frame.
    for (int i = 0; i < int'(TOTAL); i++) px(16'hFFFF, 12'hFFF, 1'b0);
    fdone();
    idle(3);
    chk("full_overflow", 32'(overflow_out), 32'd0);
    chk("full_short", 32'(short_frame_out), 32'd0);

    // Binarize, alternating black/white across several lines.
    mode_in = 3'd1;
    for (int i = 0; i < 25; i++) begin
      if (i % 2 == 0) px(16'h0000, 12'h000, 1'b1);
      else            px(16'hFFFF, 12'hFFF, 1'b0);
    end
    fdone();
    idle(3);
    chk("bin_short", 32'(short_frame_out), 32'd1);

    // Red isolate; mode change mid-frame must not apply.
    mode_in = 3'd2;
    px(16'hC104, 12'hF00, 1'b1);
    mode_in = 3'd3;
    px(16'hC484, 12'h000, 1'b0);
    px(16'h2604, 12'h000, 1'b0);
    idle(3);
    chk("short_cleared", 32'(short_frame_out), 32'd0);
    px(16'hC104, 12'hF00, 1'b1);
    fdone();

    // Green, then blue.
    px(16'h2604, 12'h0F0, 1'b0);
    fdone();
    mode_in = 3'd4;
    px(16'h2118, 12'h00F, 1'b1);
    px(16'hC104, 12'h000, 1'b1);
    fdone();

    // Gradient over one full line plus the start of the next.
    mode_in = 3'd5;
    for (int i = 0; i < 12; i++) px(gp[i], ge[i], gd[i]);
    fdone();

    // Reserved mode acts as passthrough.
    mode_in = 3'd7;
    px(16'hC104, 12'hC22, 1'b1);
    px(16'h8410, 12'h888, 1'b0);
    fdone();

    // Threshold boundary: luma 8.
    mode_in   = 3'd1;
    thresh_in = 5'd8;
    px(16'h8410, 12'h000, 1'b1);
    fdone();
    thresh_in = 5'd7;
    px(16'h8410, 12'hFFF, 1'b0);
    fdone();

    // Overflow frame, then a short frame clearing it.
    mode_in   = 3'd0;
    thresh_in = 5'd5;
    for (int i = 0; i < int'(TOTAL) + 1; i++) px(16'hFFFF, 12'hFFF, 1'b0);
    idle(3);
    chk("overflow_set", 32'(overflow_out), 32'd1);
    fdone();
    idle(3);
    chk("overflow_sticky", 32'(overflow_out), 32'd1);
    chk("overflow_not_short", 32'(short_frame_out), 32'd0);
    px(16'h1234, 12'h14A, 1'b1);
    idle(3);
    chk("overflow_cleared", 32'(overflow_out), 32'd0);
    for (int i = 0; i < 4; i++) px(16'h1234, 12'h14A, 1'b1);
    fdone();
    idle(3);
    chk("short_set", 32'(short_frame_out), 32'd1);

    // frame_done coincident with a valid pixel.
    px(16'hFFFF, 12'hFFF, 1'b0);
    px(16'hFFFF, 12'hFFF, 1'b0);
    px(16'h0000, 12'h000, 1'b1, 1'b1);
    px(16'hC104, 12'hC22, 1'b1);

    // Reset mid-frame drops the in-flight pixel.
    for (int i = 0; i < 20; i++) px(16'hFFFF, 12'hFFF, 1'b0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("rst_flush_pending", 32'(q.size()), 32'd1);
    q.delete();
    in_cap = 1'b0;
    cnt    = 0;
    chk("rst_mid_wr_en", 32'(wr_if.wr_en_out), 32'd0);
    for (int i = 0; i < 5; i++) px(16'hFFFF, 12'hFFF, 1'b0);
    idle(3);
    fdone();
    px(16'h8410, 12'h888, 1'b0);
    px(16'h8410, 12'h888, 1'b0);
    fdone();
    idle(4);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
